// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//   8-bit accumulator datapath driven by an external multi-cycle controller.
//   Each clock it executes whatever control word is presented: PC/IR/MR
//   loads, accumulator A updates through the ALU and shifter, register-file
//   writes and the output latch. There is no internal sequencing; every
//   operation completes in one clock and all registers sample pre-edge values.
//
// Ports
//   clk, reset         clock, synchronous active-high reset (clears all state)
//   IRload, MRload     load IR / MR from mem_rdata
//   Jmpmuxsel, PCload  PC next-value select (PC+1, abs, PC-off, PC+off), load
//   MemInst            memory address select: 0 = PC, 1 = MR
//   memWr              memory write strobe, passed through to mem_we
//   Asel, Aload        A source select (shifter, R, in_data, mem_rdata), load
//   RFwr               write A into RF[IR[3:0]]
//   ALUsel, Shiftsel   ALU operation and shifter operation
//   outen              latch A into out_data
//   in_data            external input port
//   mem_rdata          memory read data (combinational from mem_addr)
//   mem_addr/_wdata/_we  external memory interface
//   instr, wd          IR and A returned to the controller
//   out_data           output latch
// ---------------------------------------------------------------------------
module cpu_datapath #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IRload,
  input  logic [1:0]        Jmpmuxsel,
  input  logic              PCload,
  input  logic              MemInst,
  input  logic              MRload,
  input  logic              memWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              RFwr,
  input  logic [2:0]        ALUsel,
  input  logic [1:0]        Shiftsel,
  input  logic              outen,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [7:0]        instr,
  output logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] out_data
);

  localparam int RF_AW = $clog2(RF_DEPTH);

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [7:0]        ir_q,  ir_d;
  logic [ADDR_W-1:0] mr_q,  mr_d;
  logic [DATA_W-1:0] a_q,   a_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] rf_q [RF_DEPTH];

  logic [RF_AW-1:0]  rf_idx;
  logic [DATA_W-1:0] r_op;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] shf_res;
  logic [ADDR_W-1:0] jmp_off;

  // ALU: carry/borrow are discarded, everything wraps mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] r,
                                                input logic [2:0]        sel);
    logic [DATA_W-1:0] res;
    case (sel)
      3'b000:  res = a;
      3'b001:  res = a & r;
      3'b010:  res = a | r;
      3'b011:  res = ~a;
      3'b100:  res = a + r;
      3'b101:  res = a - r;
      3'b110:  res = a + DATA_W'(1);
      default: res = a - DATA_W'(1);
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] x,
                                                  input logic [1:0]        sel);
    logic [DATA_W-1:0] res;
    case (sel)
      2'b00:   res = x;
      2'b01:   res = {x[DATA_W-2:0], 1'b0};
      2'b10:   res = {1'b0, x[DATA_W-1:1]};
      default: res = {x[0], x[DATA_W-1:1]};
    endcase
    return res;
  endfunction

  assign rf_idx  = ir_q[RF_AW-1:0];
  assign r_op    = rf_q[rf_idx];
  assign alu_res = alu_op(a_q, r_op, ALUsel);
  assign shf_res = shift_op(alu_res, Shiftsel);
  // Relative jump offset is the unsigned 3-bit IR field.
  assign jmp_off = ADDR_W'(ir_q[2:0]);

  assign mem_addr  = MemInst ? mr_q : pc_q;
  assign mem_wdata = a_q;
  assign mem_we    = memWr;
  assign instr     = ir_q;
  assign wd        = a_q;
  assign out_data  = out_q;

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mr_d  = mr_q;
    a_d   = a_q;
    out_d = out_q;

    if (PCload) begin
      case (Jmpmuxsel)
        2'b00:   pc_d = pc_q + ADDR_W'(1);
        2'b01:   pc_d = ADDR_W'(mem_rdata);
        2'b10:   pc_d = pc_q - jmp_off;
        default: pc_d = pc_q + jmp_off;
      endcase
    end

    if (IRload) ir_d = mem_rdata[7:0];
    if (MRload) mr_d = ADDR_W'(mem_rdata);
    if (outen)  out_d = a_q;

    if (Aload) begin
      case (Asel)
        2'b00:   a_d = shf_res;
        2'b01:   a_d = r_op;
        2'b10:   a_d = in_data;
        default: a_d = mem_rdata;
      endcase
    end
  end

  // --- register stage: all state samples pre-edge values ---
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mr_q  <= '0;
      a_q   <= '0;
      out_q <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mr_q  <= mr_d;
      a_q   <= a_d;
      out_q <= out_d;
      if (RFwr) rf_q[rf_idx] <= a_q;
    end
  end

endmodule
